// File: rtl/ppgen_bw12_stage_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ppgen_bw12_stage_if : operand/partial-product handshake bundle     |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
interface ppgen_bw12_stage_if;
  logic         in_valid;
  logic         in_ready;
  logic [11:0]  in_a;
  logic [11:0]  in_b;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [143:0] pp;

  modport master (
    output in_valid, in_a, in_b, flush, out_ready,
    input  in_ready, out_valid, pp
  );

  modport slave (
    input  in_valid, in_a, in_b, flush, out_ready,
    output in_ready, out_valid, pp
  );
endinterface
`default_nettype wire

// File: rtl/ppgen_bw12_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ppgen_bw12_stage : Baugh-Wooley 12x12 partial-product generator    |
// | with a skid buffer and registered elastic output.  Revision: 1.0   |
// +------------------------------------------------------------------+
module ppgen_bw12_stage #(
  parameter int W = 12
) (
  input wire logic          clk,
  input wire logic          rst,
  ppgen_bw12_stage_if.slave bus
);
  localparam int PPW = W * W;

  if (W != 12) begin : g_bad_width
    $error("ppgen_bw12_stage: W must be 12");
  end

  logic [W-1:0]   skid_a;
  logic [W-1:0]   skid_b;
  logic           skid_v;
  logic           out_valid;
  logic [PPW-1:0] pp;

  logic           accept;
  logic           load;
  logic [W-1:0]   src_a;
  logic [W-1:0]   src_b;
  logic [PPW-1:0] pp_next;

  assign accept = bus.in_valid & ~skid_v;
  assign load   = ~out_valid | bus.out_ready;

  // Skid contents always go out before the live input.
  assign src_a  = skid_v ? skid_a : bus.in_a;
  assign src_b  = skid_v ? skid_b : bus.in_b;

  for (genvar i = 0; i < W; i++) begin : g_row
    for (genvar j = 0; j < W; j++) begin : g_col
      if ((i == W - 1) != (j == W - 1)) begin : g_neg
        assign pp_next[W*i+j] = ~(src_a[j] & src_b[i]);
      end else begin : g_pos
        assign pp_next[W*i+j] = src_a[j] & src_b[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_a    <= '0;
      skid_b    <= '0;
      skid_v    <= 1'b0;
      out_valid <= 1'b0;
      pp        <= '0;
    end else if (bus.flush) begin
      skid_v    <= 1'b0;
      out_valid <= 1'b0;
    end else if (load) begin
      if (skid_v) begin
        pp        <= pp_next;
        out_valid <= 1'b1;
        skid_v    <= 1'b0;
      end else if (accept) begin
        pp        <= pp_next;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_a <= bus.in_a;
      skid_b <= bus.in_b;
      skid_v <= 1'b1;
    end
  end

  assign bus.in_ready  = ~skid_v;
  assign bus.out_valid = out_valid;
  assign bus.pp        = pp;
endmodule
`default_nettype wire

// File: tb/tb_ppgen_bw12_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ppgen_bw12_stage : directed bench for ppgen_bw12_stage          |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module tb_ppgen_bw12_stage;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  ppgen_bw12_stage_if bus ();

  ppgen_bw12_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weighted sum of the array plus the two consumer-side constants.
  function automatic logic [23:0] inv(input logic [143:0] v);
    logic [23:0] s;
    s = 24'h801000;
    for (int i = 0; i < 12; i++)
      for (int j = 0; j < 12; j++)
        s = s + (24'(v[12*i+j]) << (i + j));
    return s;
  endfunction

  function automatic logic [23:0] prod(input logic [11:0] a, input logic [11:0] b);
    int x;
    x = int'($signed(a)) * int'($signed(b));
    return x[23:0];
  endfunction

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [143:0] e1;
    logic [143:0] e2;
    logic [23:0]  q[$];
    logic [23:0]  last;
    bit           push;
    bit           pop;

    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    e1 = '0;
    for (int i = 0; i < 11; i++) e1[12*i+11] = 1'b1;
    e1[142:132] = 11'h7FF;
    e2 = e1;
    e2[143] = 1'b1;

    // Reset state
    step();
    chk("rst_ov", bus.out_valid, 0);
    chk("rst_ir", bus.in_ready, 1);
    chk("rst_pp", bus.pp, 0);
    rst = 1'b0;

    // Test 1: zero operands
    bus.in_valid = 1'b1; bus.in_a = 12'd0; bus.in_b = 12'd0; bus.out_ready = 1'b1;
    step();
    chk("t1_ov", bus.out_valid, 1);
    chk("t1_pp", bus.pp, e1);
    chk("t1_inv", inv(bus.pp), 24'd0);

    // Test 2: most negative squared
    bus.in_a = 12'h800; bus.in_b = 12'h800;
    step();
    chk("t2_pp", bus.pp, e2);
    chk("t2_inv", inv(bus.pp), 24'd4194304);

    // Test 3: full-throughput stream
    last = '0;
    for (int k = 0; k < 16; k++) begin
      bus.in_a = 12'($urandom());
      bus.in_b = 12'($urandom());
      last = prod(bus.in_a, bus.in_b);
      step();
      chk("t3_ov", bus.out_valid, 1);
      chk("t3_inv", inv(bus.pp), last);
    end
    bus.in_valid = 1'b0; bus.in_a = 'x; bus.in_b = 'x;
    step();
    chk("t3_idle_ov", bus.out_valid, 0);
    chk("t3_hold_inv", inv(bus.pp), last);
    step();
    chk("t3_x_inv", inv(bus.pp), last);

    // Test 4: back-pressure fills output then skid
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    bus.in_a = 12'd3; bus.in_b = 12'd5;
    step();
    chk("t4_c1_ov", bus.out_valid, 1);
    chk("t4_c1_ir", bus.in_ready, 1);
    chk("t4_c1_inv", inv(bus.pp), 24'd15);
    bus.in_a = 12'hFF9; bus.in_b = 12'd100;
    step();
    chk("t4_c2_ir", bus.in_ready, 0);
    chk("t4_c2_inv", inv(bus.pp), 24'd15);
    bus.in_a = 12'd9; bus.in_b = 12'd9;
    step();
    chk("t4_c3_ir", bus.in_ready, 0);
    chk("t4_c3_ov", bus.out_valid, 1);
    chk("t4_c3_inv", inv(bus.pp), 24'd15);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    chk("t4_d1_ov", bus.out_valid, 1);
    chk("t4_d1_ir", bus.in_ready, 1);
    chk("t4_d1_inv", inv(bus.pp), 24'hFFFD44);
    step();
    chk("t4_d2_ov", bus.out_valid, 0);

    // Test 5: flush with both entries full
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    bus.in_a = 12'd10; bus.in_b = 12'd10;
    step();
    bus.in_a = 12'hFFF; bus.in_b = 12'hFFF;
    step();
    chk("t5_full_ir", bus.in_ready, 0);
    bus.flush = 1'b1; bus.in_a = 12'd20; bus.in_b = 12'd20;
    step();
    chk("t5_ov", bus.out_valid, 0);
    chk("t5_ir", bus.in_ready, 1);
    chk("t5_pp_kept", inv(bus.pp), 24'd100);
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    chk("t5_no_leak", bus.out_valid, 0);
    // Accept in a flush cycle is discarded
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_a = 12'd7; bus.in_b = 12'd7;
    step();
    chk("t5b_ov", bus.out_valid, 0);
    chk("t5b_ir", bus.in_ready, 1);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    step();
    chk("t5b_no_leak", bus.out_valid, 0);
    chk("t5b_pp_kept", inv(bus.pp), 24'd100);

    // Random back-pressure scoreboard
    for (int k = 0; k < 200; k++) begin
      chk("rnd_ov", bus.out_valid, (q.size() > 0));
      chk("rnd_ir", bus.in_ready, (q.size() < 2));
      if (q.size() > 0) chk("rnd_inv", inv(bus.pp), q[0]);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.in_valid) begin
        bus.in_a = 12'($urandom());
        bus.in_b = 12'($urandom());
      end else begin
        bus.in_a = 'x;
        bus.in_b = 'x;
      end
      pop  = (q.size() > 0) && bus.out_ready;
      push = (q.size() < 2) && bus.in_valid;
      last = push ? prod(bus.in_a, bus.in_b) : 24'd0;
      step();
      if (pop) void'(q.pop_front());
      if (push) q.push_back(last);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.in_a = '0; bus.in_b = '0;
    step();
    step();
    chk("drain_ov", bus.out_valid, 0);
    q.delete();

    // Test 6: async reset mid-stream
    bus.in_valid = 1'b1; bus.in_a = 12'd2; bus.in_b = 12'd3;
    step();
    chk("t6_pre_ov", bus.out_valid, 1);
    chk("t6_pre_inv", inv(bus.pp), 24'd6);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_ov", bus.out_valid, 0);
    chk("t6_rst_ir", bus.in_ready, 1);
    chk("t6_rst_pp", bus.pp, 0);
    step();
    rst = 1'b0;
    bus.in_a = 12'hFFB; bus.in_b = 12'd6;
    step();
    chk("t6_post_ov", bus.out_valid, 1);
    chk("t6_post_inv", inv(bus.pp), 24'hFFFFE2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
